pc_branch_seq: RTL
==================

// Module: pc_branch_seq
// PURPOSE
//  Program-counter sequencer for the 8-bit CPU: owns the PC register, decodes
//  the class-3 branch instruction group and applies it. Adds call/return over a
//  parametrised hardware return stack, relative branches and sticky stack
//  errors. Sits between instruction fetch (drives PC) and the PSW/accumulator.
// PARAMETERS
//  PC_W       12  PC width in bits; legal range 8..16
//  STK_DEPTH  4   return-stack entries; legal range 1..16
//  PSW_W      8   PSW width; legal range 1..8; condition index >= PSW_W reads 0
// PORTS
//  CLK      in   1      clock, rising edge
//  RST      in   1      synchronous reset, active-high
//  EN       in   1      advance: 1 = execute PRG this cycle, 0 = hold all state
//  PRG      in   16     current instruction word
//  PSW      in   PSW_W  status flags
//  RADDR    in   PC_W   register-jump target (accumulator/pair)
//  ERR_CLR  in   1      clears STK_OVF/STK_UNF
//  PC       out  PC_W   program counter
//  TAKEN    out  1      registered: PC was loaded by a branch last cycle
//  SP       out  clog2(STK_DEPTH+1)  stack occupancy, 0..STK_DEPTH
//  STK_OVF  out  1      sticky: CALL attempted with stack full
//  STK_UNF  out  1      sticky: RET attempted with stack empty
// BEHAVIOUR
//  Reset: PC=0, TAKEN=0, SP=0, STK_OVF=0, STK_UNF=0; stack contents don't-care.
//  RST mid-operation wins over every other input in that cycle.
//  Decode: INS3=PRG[15:14]==2'b11; IF=PRG[13]; NT=PRG[12]; CND=PRG[11:9];
//   MODE={PRG[8],PRG[7]}; OFF=PRG[6:0].
//  Target by MODE: 00 page-0 {0,OFF}; 01 in-page {PC[PC_W-1:7],OFF};
//   10 register RADDR; 11 relative PC+sext(OFF) (-64..+63), mod 2^PC_W.
//  IF=1: conditional jump, taken iff NT ^ PSW[CND]; else PC<=PC+1.
//  IF=0: CND selects op: 000 JMP; 001 CALL; 010 RET; 011..111 treated as JMP.
//  CALL: push PC+1 (mod 2^PC_W), SP+1, PC<=target. Full: no push, SP holds,
//   STK_OVF<=1, jump still taken.
//  RET: PC<=top entry, SP-1 (MODE/OFF ignored). Empty: PC<=PC+1, SP holds,
//   STK_UNF<=1, TAKEN<=0.
//  Non-INS3 with EN=1: PC<=PC+1, wraps max->0.
//  All updates occur on the CLK edge where EN=1: 1-cycle latency PRG->PC.
//  TAKEN<=1 on the edge that loads a branch/CALL/RET target, else 0.
//  TAKEN<=0 while EN=0.
//  EN=0: PC, SP, stack and flags hold; ERR_CLR still acts.
//  ERR_CLR and a new error in the same cycle: the flag ends set (set wins).
//  Stack is LIFO; entry SP-1 is top; no state machine beyond PC/SP/flags.
// TESTING
//  1 Reset, EN=1, PRG=16'h0000 x5 -> PC 1,2,3,4,5; TAKEN=0; PC_W=8 at 8'hFF -> 0.
//  2 PSW=8'h04; PRG=16'hE481 (IF=1,NT=0,CND=2,MODE=01,OFF=1) at PC=12'h123 ->
//    PC=12'h101, TAKEN=1; with NT=1 (16'hF481) -> PC=12'h124, TAKEN=0.
//  3 Relative: PRG=16'hC1FE (JMP,MODE=11,OFF=-2) at PC=12'h010 -> PC=12'h00E;
//    at PC=0 -> PC=12'hFFE.
//  4 CALL 16'hC205 (page-0 5) at PC=0x40 -> PC=5, SP=1; RET 16'hC400 -> PC=0x41,
//    SP=0; RET again -> PC=0x42, STK_UNF=1; ERR_CLR -> STK_UNF=0.
//  5 STK_DEPTH=4: five CALLs -> SP=4, STK_OVF=1; four RETs return the first
//    four pushed addresses in reverse order.
//  6 EN=0 for 3 cycles mid-CALL sequence -> PC/SP frozen, TAKEN=0; RST pulse
//    with EN=1 and CALL present -> PC=0, SP=0, flags 0.

Source files
------------

// File: rtl/pc_branch_seq.sv
// Program-counter sequencer: owns PC, decodes the class-3 branch group
// (jump/conditional/call/return) and manages a LIFO hardware return stack.
module pc_branch_seq #(
    parameter int unsigned PC_W      = 12,
    parameter int unsigned STK_DEPTH = 4,
    parameter int unsigned PSW_W     = 8
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               EN,
    input  logic [15:0]                        PRG,
    input  logic [PSW_W-1:0]                   PSW,
    input  logic [PC_W-1:0]                    RADDR,
    input  logic                               ERR_CLR,
    output logic [PC_W-1:0]                    PC,
    output logic                               TAKEN,
    output logic [$clog2(STK_DEPTH+1)-1:0]     SP,
    output logic                               STK_OVF,
    output logic                               STK_UNF
);

    localparam int unsigned SP_W  = $clog2(STK_DEPTH + 1);
    localparam int unsigned OFF_W = 7;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    // Sized to the full SP index range so SP indexes it without truncation.
    logic [PC_W-1:0] stk_q [2**SP_W];

    logic             ins3, is_if, nt;
    logic [2:0]       cnd;
    logic [1:0]       mode;
    logic [OFF_W-1:0] off;
    logic [7:0]       psw_ext;
    logic             cond_bit;
    logic [PC_W-1:0]  pc_inc, target, stk_top;
    logic             push_en;
    logic             stk_full, stk_empty;

    always_comb begin
        ins3  = (PRG[15:14] == 2'b11);
        is_if = PRG[13];
        nt    = PRG[12];
        cnd   = PRG[11:9];
        mode  = PRG[8:7];
        off   = PRG[6:0];
    end

    // Flags above PSW_W read as zero through the zero-extension.
    always_comb begin
        psw_ext  = 8'(PSW);
        cond_bit = psw_ext[cnd];
    end

    always_comb begin
        pc_inc    = pc_q + PC_W'(1);
        stk_top   = stk_q[sp_q - SP_W'(1)];
        stk_full  = (sp_q == SP_W'(STK_DEPTH));
        stk_empty = (sp_q == '0);
        unique case (mode)
            2'b00:   target = PC_W'(off);
            2'b01:   target = {pc_q[PC_W-1:OFF_W], off};
            2'b10:   target = RADDR;
            default: target = pc_q + {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
        endcase
    end

    // Next-state for PC, SP, TAKEN and the sticky error flags.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        taken_d = 1'b0;
        ovf_d   = ovf_q & ~ERR_CLR;
        unf_d   = unf_q & ~ERR_CLR;
        push_en = 1'b0;
        if (EN) begin
            pc_d = pc_inc;
            if (ins3) begin
                if (is_if) begin
                    if (nt ^ cond_bit) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end else begin
                    unique case (cnd)
                        3'b001: begin
                            pc_d    = target;
                            taken_d = 1'b1;
                            if (stk_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                push_en = 1'b1;
                                sp_d    = sp_q + SP_W'(1);
                            end
                        end
                        3'b010: begin
                            if (stk_empty) begin
                                unf_d = 1'b1;
                            end else begin
                                pc_d    = stk_top;
                                sp_d    = sp_q - SP_W'(1);
                                taken_d = 1'b1;
                            end
                        end
                        default: begin
                            pc_d    = target;
                            taken_d = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset; only entries below SP are ever read.
    always_ff @(posedge CLK) begin
        if (!RST && push_en) begin
            stk_q[sp_q] <= pc_inc;
        end
    end

    assign PC      = pc_q;
    assign TAKEN   = taken_q;
    assign SP      = sp_q;
    assign STK_OVF = ovf_q;
    assign STK_UNF = unf_q;

endmodule
